// File: rtl/mzc_pkg.sv
// Shared constants, types and the zone time function for the multi-zone world clock.
package mzc_pkg;

  localparam int MIN_PER_DAY = 1440;
  localparam int OFF_Q_MIN   = -48;
  localparam int OFF_Q_MAX   = 56;

  typedef logic signed [7:0] offset_q_t;

  typedef struct packed {
    logic [4:0] hh;
    logic [5:0] mm;
  } hhmm_t;

  typedef struct packed {
    hhmm_t      t;
    logic [1:0] shift;
  } zone_time_t;

  // 13 bits: the largest sum (23:59 + 14:00 + 1:00 DST = 2339 min) does not fit in 12.
  function automatic zone_time_t zone_time(input hhmm_t base, input offset_q_t off,
                                           input logic dst);
    logic signed [12:0] t;
    zone_time_t         r;
    t = $signed({8'd0, base.hh}) * 13'sd60 + $signed({7'd0, base.mm})
        + $signed({{5{off[7]}}, off}) * 13'sd15 + (dst ? 13'sd60 : 13'sd0);
    r.shift = 2'b00;
    if (t < 13'sd0) begin
      t       = t + $signed(13'(MIN_PER_DAY));
      r.shift = 2'b11;
    end else if (t >= $signed(13'(MIN_PER_DAY))) begin
      t       = t - $signed(13'(MIN_PER_DAY));
      r.shift = 2'b01;
    end
    r.t.hh = 5'(t / 13'sd60);
    r.t.mm = 6'(t % 13'sd60);
    return r;
  endfunction

endpackage

// File: rtl/mzc_tick_gen.sv
// Seconds prescaler: counts 0..CLK_HZ-1 and flags the last count of each second.
module mzc_tick_gen #(
  parameter int CLK_HZ = 100
) (
  input  logic clk,
  input  logic reset,
  output logic sec_tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == CW'(CLK_HZ - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign sec_tick = (cnt == CW'(CLK_HZ - 1));

endmodule

// File: rtl/multi_zone_clock.sv
// N-zone 24h world clock: base HH:MM:SS, per-zone quarter-hour offsets, registered zone view.
// Build option MZC_DST_EN adds a per-zone DST bit toggled by dst_toggle (+60 min in zone math).
module multi_zone_clock
  import mzc_pkg::*;
#(
  parameter int CLK_HZ  = 100,
  parameter int N_ZONES = 4,
  parameter int ZONE_W  = $clog2(N_ZONES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hour_inc,
  input  logic              min_inc,
  input  logic              zone_next,
  input  logic              offset_up,
  input  logic              offset_down,
  input  logic              dst_toggle,
  output logic              sec_tick,
  output logic              day_rollover,
  output logic [4:0]        base_hh,
  output logic [5:0]        base_mm,
  output logic [5:0]        base_ss,
  output logic [ZONE_W-1:0] zone_sel,
  output logic [4:0]        zone_hh,
  output logic [5:0]        zone_mm,
  output logic [1:0]        zone_day_shift,
  output logic              zone_dst
);

  logic [5:0] btn, btn_prev, press;
  logic       manual_set, tick_take, sel_dst;
  offset_q_t  offset [N_ZONES];
  offset_q_t  sel_off;
  zone_time_t zt;

  mzc_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk      (clk),
    .reset    (reset),
    .sec_tick (sec_tick)
  );

  // Bit order: 0 hour, 1 minute, 2 zone, 3 up, 4 down, 5 dst.
  assign btn   = {dst_toggle, offset_down, offset_up, zone_next, min_inc, hour_inc};
  assign press = btn & ~btn_prev;

  assign manual_set   = press[0] | press[1];
  assign tick_take    = sec_tick & ~manual_set;
  assign day_rollover = tick_take && base_hh == 5'd23 && base_mm == 6'd59 && base_ss == 6'd59;

  assign sel_off = offset[zone_sel];

`ifdef MZC_DST_EN
  logic [N_ZONES-1:0] dst_bits;
  assign sel_dst = dst_bits[zone_sel];

  always_ff @(posedge clk) begin
    if (reset) begin
      dst_bits <= '0;
    end else if (press[5]) begin
      dst_bits[zone_sel] <= ~dst_bits[zone_sel];
    end
  end
`else
  logic unused_dst;
  assign sel_dst    = 1'b0;
  assign unused_dst = press[5];
`endif

  assign zt = zone_time({base_hh, base_mm}, sel_off, sel_dst);

  // A manual set wins over the tick; the dropped second is simply lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_hh <= '0;
      base_mm <= '0;
      base_ss <= '0;
    end else if (manual_set) begin
      if (press[0]) base_hh <= (base_hh == 5'd23) ? 5'd0 : base_hh + 5'd1;
      if (press[1]) begin
        base_mm <= (base_mm == 6'd59) ? 6'd0 : base_mm + 6'd1;
        base_ss <= '0;
      end
    end else if (tick_take) begin
      if (base_ss == 6'd59) begin
        base_ss <= '0;
        if (base_mm == 6'd59) begin
          base_mm <= '0;
          base_hh <= (base_hh == 5'd23) ? 5'd0 : base_hh + 5'd1;
        end else begin
          base_mm <= base_mm + 6'd1;
        end
      end else begin
        base_ss <= base_ss + 6'd1;
      end
    end
  end

  // Offset edits land on the zone selected before any same-cycle zone_next.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_prev <= btn;
      zone_sel <= '0;
      for (int i = 0; i < N_ZONES; i++) offset[i] <= '0;
    end else begin
      btn_prev <= btn;
      if (press[3] && !press[4] && sel_off < offset_q_t'(OFF_Q_MAX)) begin
        offset[zone_sel] <= sel_off + 8'sd1;
      end else if (press[4] && !press[3] && sel_off > offset_q_t'(OFF_Q_MIN)) begin
        offset[zone_sel] <= sel_off - 8'sd1;
      end
      if (press[2]) begin
        zone_sel <= (zone_sel == ZONE_W'(N_ZONES - 1)) ? '0 : zone_sel + ZONE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      zone_hh        <= '0;
      zone_mm        <= '0;
      zone_day_shift <= '0;
      zone_dst       <= 1'b0;
    end else begin
      zone_hh        <= zt.t.hh;
      zone_mm        <= zt.t.mm;
      zone_day_shift <= zt.shift;
      zone_dst       <= sel_dst;
    end
  end

endmodule
